serial_tx_buff: RTL and testbench
=================================

Name: serial_tx_buff

Overview:
- Parallel-to-serial transmit buffer; the transmit end of the serial link that the receive-side deserializer reassembles into NDATA-bit words.
- Accepts one NDATA-bit word over a valid/ready handshake and shifts it out one bit per enabled clock, MSB first.
- Drives a bit index (cntout) matching the receiver's count convention, so the receiver's count==0 latch point lines up with word boundaries.

Parameters:
- NDATA, 128, word width in bits; power of two, >= 4.
- NDATA_LOG (localparam), $clog2(NDATA), width of the bit counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- din  input  NDATA  parallel word to transmit.
- load_valid  input  1  din is valid.
- load_ready  output  1  block can accept a word; high only in IDLE.
- ena  input  1  bit strobe; while high in SHIFT, advance one bit per clk.
- dout  output  1  serial data bit.
- cntout  output  NDATA_LOG  index of the bit currently on dout (0 = first, MSB).
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse after the last bit has been held.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift register=0, counter=0, dout=0, cntout=0, busy=0, done=0, load_ready=0 while asserted.
  - load_ready goes to 1 on the first clk edge after release.
- IDLE:
  - load_ready=1, busy=0, dout=0.
  - On load_valid && load_ready at a clk edge: capture din into the shift register, counter=0, go to SHIFT.
  - load_valid without ready is never captured.
- SHIFT:
  - Latency: dout = captured din[NDATA-1] in the first cycle after the capture edge; cntout=0.
  - dout is always shift register bit NDATA-1; cntout = counter.
  - On a clk edge with ena=1 and counter != NDATA-1: shift left by one (LSB filled with 0), counter+1.
  - On a clk edge with ena=1 and counter == NDATA-1: go to DONE; counter wraps to 0; shift register cleared.
  - ena=0: shift register and counter hold; dout and cntout are stable for any gap length.
  - load_valid is ignored (load_ready=0); din may change freely.
- DONE:
  - Exactly one cycle: done=1, busy=1, dout=0, cntout=0, load_ready=0.
  - Unconditionally returns to IDLE.
- Minimum word-to-word gap: NDATA enabled cycles + 1 DONE cycle + 1 IDLE handshake cycle.
- Reset mid-word aborts immediately to the reset values; no done pulse; the partial word is discarded.
- Outputs are registered or decoded from the registered state only; there is no combinational path from din, load_valid or ena to any output.
- Counter width is exactly NDATA_LOG; the NDATA-1 -> 0 transition is the natural wrap, with no extra compare bit.

Decomposition:
- Shared package: state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2 (2'd3 unused, decodes to IDLE); NDATA_LOG derivation via $clog2.
- One natural sub-module: shift_reg_load. Parallel-load/left-shift register, NDATA wide, with ports:
  - clk, rst
  - load, shift, pdin
  - msb
  - Load has priority over shift; synchronous clear.
- This pairs with the existing serial-in shift register used on the receive side.

Test Plan (bench uses NDATA=8 unless stated):
- Reset: hold rst=0 with random inputs -> dout=0, cntout=0, busy=0, done=0, load_ready=0; first edge after release -> load_ready=1.
- Basic word: load 8'hA5, ena=1 continuous -> dout 1,0,1,0,0,1,0,1 on cycles 1-8 after capture, cntout 0..7; done=1 on cycle 9; load_ready=1 on cycle 10.
- Ena gaps: load 8'hC3, ena pattern 1,0,0,1,1,0,... -> each bit held for exactly the gap length; serial stream still 1,1,0,0,0,0,1,1; done follows the 8th enabled edge.
- Load while busy: present load_valid with 8'hFF during SHIFT of 8'h0F -> stream stays 0,0,0,0,1,1,1,1; 8'hFF is sent only if load_valid is still high in IDLE.
- Reset mid-word: assert rst after bit 3 of 8'h96 -> immediate reset values, no done pulse; next load of 8'h01 -> stream 0,0,0,0,0,0,0,1.
- Loopback, NDATA=128: connect to the receive-side deserializer (serial data/clock shared); send 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 -> receiver parallel output equals the word after the count wraps to 0.

Source files
------------

// File: rtl/serial_tx_buff_pkg.sv
// Shared definitions for the serial transmit buffer: FSM encoding and counter sizing.
package serial_tx_buff_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Bit-counter width for an n-bit word (n is a power of two, so the counter wraps naturally).
   function automatic int cnt_width(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/serial_tx_buff_shift_reg_load.sv
// Parallel-load / left-shift register; load wins over shift, MSB exposed as the serial bit.
module shift_reg_load #(
   parameter int NDATA = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [NDATA-1:0] pdin,
   output logic             msb
);

   logic [NDATA-1:0] data;

   // A synchronous clear is a load of zero; the owner drives pdin accordingly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data <= '0;
      end else if (load) begin
         data <= pdin;
      end else if (shift) begin
         data <= {data[NDATA-2:0], 1'b0};
      end
   end

   assign msb = data[NDATA-1];

endmodule

// File: rtl/serial_tx_buff.sv
// Transmit buffer: takes one word over valid/ready and shifts it out MSB first, one bit per ena.
module serial_tx_buff
   import serial_tx_buff_pkg::*;
#(
   parameter int  NDATA     = 128,
   localparam int NDATA_LOG = cnt_width(NDATA)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NDATA-1:0]     din,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic                 ena,
   output logic                 dout,
   output logic [NDATA_LOG-1:0] cntout,
   output logic                 busy,
   output logic                 done
);

   state_t               state;
   logic [NDATA_LOG-1:0] counter;
   logic                 msb;
   logic                 capture;
   logic                 last_bit;
   logic                 sr_load;
   logic                 sr_shift;
   logic [NDATA-1:0]     sr_pdin;

   assign capture  = (state == ST_IDLE) && load_valid && load_ready;
   assign last_bit = (state == ST_SHIFT) && ena && (counter == NDATA_LOG'(NDATA - 1));

   // The final enabled edge reloads zeros, so the register is clean for the next word.
   assign sr_load  = capture || last_bit;
   assign sr_shift = (state == ST_SHIFT) && ena;
   assign sr_pdin  = (state == ST_IDLE) ? din : '0;

   shift_reg_load #(
      .NDATA (NDATA)
   ) u_shift_reg_load (
      .clk   (clk),
      .rst   (rst),
      .load  (sr_load),
      .shift (sr_shift),
      .pdin  (sr_pdin),
      .msb   (msb)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         counter    <= '0;
         load_ready <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               load_ready <= 1'b1;
               busy       <= 1'b0;
               done       <= 1'b0;
               if (capture) begin
                  state      <= ST_SHIFT;
                  counter    <= '0;
                  load_ready <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (ena) begin
                  counter <= counter + NDATA_LOG'(1);
                  if (last_bit) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state      <= ST_IDLE;
               done       <= 1'b0;
               busy       <= 1'b0;
               load_ready <= 1'b1;
            end
            default: begin
               state      <= ST_IDLE;
               counter    <= '0;
               load_ready <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b0;
            end
         endcase
      end
   end

   assign dout   = (state == ST_SHIFT) && msb;
   assign cntout = counter;

endmodule

// File: tb/tb_serial_tx_buff.sv
// Directed bench: 8-bit instance for protocol cases, 128-bit instance looped into a receiver model.
module tb_serial_tx_buff;

   logic         clk = 1'b0;
   logic         rst = 1'b0;

   logic [7:0]   din = '0;
   logic         load_valid = 1'b0;
   logic         load_ready;
   logic         ena = 1'b0;
   logic         dout;
   logic [2:0]   cntout;
   logic         busy;
   logic         done;

   logic [127:0] din128 = '0;
   logic         lv128 = 1'b0;
   logic         ready128;
   logic         ena128 = 1'b0;
   logic         dout128;
   logic [6:0]   cnt128;
   logic         busy128;
   logic         done128;

   logic [127:0] rx_sr = '0;
   logic [127:0] rx_word = '0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   serial_tx_buff #(.NDATA(8)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .din        (din),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .ena        (ena),
      .dout       (dout),
      .cntout     (cntout),
      .busy       (busy),
      .done       (done)
   );

   serial_tx_buff #(.NDATA(128)) u_dut128 (
      .clk        (clk),
      .rst        (rst),
      .din        (din128),
      .load_valid (lv128),
      .load_ready (ready128),
      .ena        (ena128),
      .dout       (dout128),
      .cntout     (cnt128),
      .busy       (busy128),
      .done       (done128)
   );

   // Receive-side deserializer: shift in on enabled edges, latch the word as the count wraps.
   always @(posedge clk) begin
      if (busy128 && !done128 && ena128) begin
         rx_sr <= {rx_sr[126:0], dout128};
         if (cnt128 == 7'd127) rx_word <= {rx_sr[126:0], dout128};
      end
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // mode 0: ena always high; mode 1: ena pattern 1,0,0,1,1,0 repeating.
   task automatic run_word(input logic [7:0] w, input int mode, input logic lv_during,
                           input logic [7:0] din_during, input string tag);
      int idx;
      int cyc;
      din = w;
      load_valid = 1'b1;
      ena = 1'b0;
      tick();
      load_valid = lv_during;
      din = din_during;
      idx = 0;
      cyc = 0;
      while (idx < 8 && cyc < 100) begin
         chk({tag, "_dout"}, 128'(dout), 128'(w[7 - idx]));
         chk({tag, "_cnt"}, 128'(cntout), 128'(idx));
         chk({tag, "_busy"}, 128'(busy), 128'(1));
         chk({tag, "_ready"}, 128'(load_ready), 128'(0));
         chk({tag, "_done_early"}, 128'(done), 128'(0));
         if (mode == 0) ena = 1'b1;
         else ena = (cyc % 6 == 0) || (cyc % 6 == 3) || (cyc % 6 == 4);
         tick();
         if (ena) idx++;
         cyc++;
      end
      if (idx < 8) chk({tag, "_timeout"}, 128'(0), 128'(1));
      ena = 1'b0;
      chk({tag, "_done"}, 128'(done), 128'(1));
      chk({tag, "_done_busy"}, 128'(busy), 128'(1));
      chk({tag, "_done_dout"}, 128'(dout), 128'(0));
      chk({tag, "_done_cnt"}, 128'(cntout), 128'(0));
      chk({tag, "_done_ready"}, 128'(load_ready), 128'(0));
      tick();
      chk({tag, "_idle_ready"}, 128'(load_ready), 128'(1));
      chk({tag, "_idle_done"}, 128'(done), 128'(0));
      chk({tag, "_idle_busy"}, 128'(busy), 128'(0));
      $display("word %s %h sent", tag, w);
   endtask

   initial begin
      int n;
      logic [127:0] word;

      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         din = 8'($urandom);
         load_valid = 1'($urandom);
         ena = 1'($urandom);
         tick();
      end
      chk("rst_dout", 128'(dout), 128'(0));
      chk("rst_cnt", 128'(cntout), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_ready", 128'(load_ready), 128'(0));
      load_valid = 1'b0;
      ena = 1'b0;
      rst = 1'b1;
      #1;
      chk("rel_ready_pre", 128'(load_ready), 128'(0));
      tick();
      chk("rel_ready", 128'(load_ready), 128'(1));
      chk("rel_busy", 128'(busy), 128'(0));
      $display("reset checked");

      run_word(8'hA5, 0, 1'b0, 8'h00, "basic");
      run_word(8'hC3, 1, 1'b0, 8'h5A, "gaps");
      run_word(8'h0F, 0, 1'b1, 8'hFF, "busyload");
      run_word(8'hFF, 0, 1'b0, 8'h00, "pending");

      // Reset in the middle of 8'h96 (bits 1,0,0,1,0,1,1,0)
      din = 8'h96;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      ena = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      chk("mid_dout", 128'(dout), 128'(1));
      chk("mid_cnt", 128'(cntout), 128'(3));
      #2;
      rst = 1'b0;
      #1;
      chk("abort_dout", 128'(dout), 128'(0));
      chk("abort_cnt", 128'(cntout), 128'(0));
      chk("abort_busy", 128'(busy), 128'(0));
      chk("abort_done", 128'(done), 128'(0));
      chk("abort_ready", 128'(load_ready), 128'(0));
      tick();
      chk("abort_hold_done", 128'(done), 128'(0));
      ena = 1'b0;
      rst = 1'b1;
      tick();
      chk("abort_rel_ready", 128'(load_ready), 128'(1));
      chk("abort_rel_done", 128'(done), 128'(0));
      $display("mid-word reset checked");
      run_word(8'h01, 0, 1'b0, 8'h00, "after_abort");

      // 128-bit loopback
      word = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      chk("lb_ready", 128'(ready128), 128'(1));
      din128 = word;
      lv128 = 1'b1;
      tick();
      lv128 = 1'b0;
      din128 = '0;
      ena128 = 1'b1;
      n = 0;
      while (!done128 && n < 300) begin
         tick();
         n++;
      end
      ena128 = 1'b0;
      chk("lb_done", 128'(done128), 128'(1));
      chk("lb_cycles", 128'(n), 128'(128));
      chk("lb_word", rx_word, word);
      $display("loopback word %h received %h", word, rx_word);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
